// File: rtl/systolic_array_os_if.sv
// Stream/control bundle between the fmap/weight buffers, the systolic array
// and the output buffer. master = buffer side, slave = array side.
interface systolic_array_os_if #(
    parameter int I_F_BW = 8,
    parameter int W_BW   = 8,
    parameter int ACC_BW = 24,
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int K_BW   = 12
);
    localparam int RIDX_BW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic                     start;
    logic                     acc_keep;
    logic [K_BW-1:0]          k_len;
    logic                     in_valid;
    logic                     in_ready;
    logic [ROWS*I_F_BW-1:0]   i_fmap;
    logic [COLS*W_BW-1:0]     i_weight;
    logic                     out_valid;
    logic                     out_ready;
    logic [RIDX_BW-1:0]       o_row_idx;
    logic [COLS*ACC_BW-1:0]   o_result;
    logic                     busy;
    logic                     done;

    modport master (
        output start, acc_keep, k_len, in_valid, i_fmap, i_weight, out_ready,
        input  in_ready, out_valid, o_row_idx, o_result, busy, done
    );

    modport slave (
        input  start, acc_keep, k_len, in_valid, i_fmap, i_weight, out_ready,
        output in_ready, out_valid, o_row_idx, o_result, busy, done
    );
endinterface

// File: rtl/systolic_array_os.sv
// Output-stationary ROWS x COLS systolic matrix-multiply engine with internal
// operand skew, start/flush/drain sequencing and row-by-row result drain.
//
// state   | meaning
// IDLE    | waiting for start; accumulators retained
// COMPUTE | accepting k_len input beats, array advances per beat
// FLUSH   | zero operands pushed for ROWS+COLS-1 cycles to finish all MACs
// DRAIN   | one accumulator row per out_valid/out_ready handshake
// DONE    | one-cycle done pulse, then IDLE
module systolic_array_os #(
    parameter int I_F_BW = 8,
    parameter int W_BW   = 8,
    parameter int ACC_BW = 24,
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int K_BW   = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    systolic_array_os_if.slave bus
);
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_COMPUTE = 3'd1;
    localparam logic [2:0] ST_FLUSH   = 3'd2;
    localparam logic [2:0] ST_DRAIN   = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    localparam int RIDX_BW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int FL_BW   = $clog2(ROWS + COLS);
    localparam int CNT_BW  = (K_BW > FL_BW) ? K_BW : FL_BW;
    localparam int P_BW    = I_F_BW + W_BW;

    localparam logic [CNT_BW-1:0]  FLUSH_LAST = CNT_BW'(ROWS + COLS - 2);
    localparam logic [RIDX_BW-1:0] ROW_LAST   = RIDX_BW'(ROWS - 1);

    logic [2:0]         state;
    logic [CNT_BW-1:0]  cnt;
    logic [RIDX_BW-1:0] row_idx;

    logic start_ok;
    logic advance;

    logic signed [I_F_BW-1:0] fmap_in [ROWS];
    logic signed [W_BW-1:0]   wgt_in  [COLS];
    logic signed [I_F_BW-1:0] skew_a  [ROWS][ROWS];
    logic signed [W_BW-1:0]   skew_b  [COLS][COLS];
    logic signed [I_F_BW-1:0] a_edge  [ROWS];
    logic signed [W_BW-1:0]   b_edge  [COLS];

    logic signed [I_F_BW-1:0] a_reg [ROWS][COLS];
    logic signed [W_BW-1:0]   b_reg [ROWS][COLS];
    logic signed [I_F_BW-1:0] a_in  [ROWS][COLS];
    logic signed [W_BW-1:0]   b_in  [ROWS][COLS];
    logic signed [P_BW-1:0]   prod  [ROWS][COLS];
    logic signed [ACC_BW-1:0] acc   [ROWS][COLS];

    logic [COLS*ACC_BW-1:0] result_row;

    assign start_ok = (state == ST_IDLE) && bus.start;
    assign advance  = ((state == ST_COMPUTE) && bus.in_valid) || (state == ST_FLUSH);

    assign bus.in_ready  = (state == ST_COMPUTE);
    assign bus.out_valid = (state == ST_DRAIN);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.done      = (state == ST_DONE);
    assign bus.o_row_idx = row_idx;
    assign bus.o_result  = result_row;

    // Sequencer: cnt is a down-counter reused for beats and flush cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            row_idx <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        row_idx <= '0;
                        if (bus.k_len != '0) begin
                            state <= ST_COMPUTE;
                            cnt   <= CNT_BW'(bus.k_len) - CNT_BW'(1);
                        end else begin
                            state <= ST_DRAIN;
                            cnt   <= '0;
                        end
                    end
                end
                ST_COMPUTE: begin
                    if (bus.in_valid) begin
                        if (cnt == '0) begin
                            state <= ST_FLUSH;
                            cnt   <= FLUSH_LAST;
                        end else begin
                            cnt <= cnt - CNT_BW'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    if (cnt == '0) begin
                        state <= ST_DRAIN;
                    end else begin
                        cnt <= cnt - CNT_BW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (bus.out_ready) begin
                        if (row_idx == ROW_LAST) begin
                            state   <= ST_DONE;
                            row_idx <= '0;
                        end else begin
                            row_idx <= row_idx + RIDX_BW'(1);
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Operands are zeroed outside COMPUTE so FLUSH pushes zeros through the array.
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            fmap_in[r] = (state == ST_COMPUTE) ? bus.i_fmap[r*I_F_BW +: I_F_BW] : '0;
        end
        for (int c = 0; c < COLS; c++) begin
            wgt_in[c] = (state == ST_COMPUTE) ? bus.i_weight[c*W_BW +: W_BW] : '0;
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_a_edge
        if (r == 0) begin : g_direct
            assign a_edge[r] = fmap_in[r];
        end else begin : g_delayed
            assign a_edge[r] = skew_a[r][r-1];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_b_edge
        if (c == 0) begin : g_direct
            assign b_edge[c] = wgt_in[c];
        end else begin : g_delayed
            assign b_edge[c] = skew_b[c][c-1];
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            if (c == 0) begin : g_a_first
                assign a_in[r][c] = a_edge[r];
            end else begin : g_a_next
                assign a_in[r][c] = a_reg[r][c-1];
            end
            if (r == 0) begin : g_b_first
                assign b_in[r][c] = b_edge[c];
            end else begin : g_b_next
                assign b_in[r][c] = b_reg[r-1][c];
            end
            assign prod[r][c] = a_in[r][c] * b_in[r][c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int j = 0; j < ROWS; j++) skew_a[r][j] <= '0;
                for (int c = 0; c < COLS; c++) begin
                    a_reg[r][c] <= '0;
                    b_reg[r][c] <= '0;
                    acc[r][c]   <= '0;
                end
            end
            for (int c = 0; c < COLS; c++) begin
                for (int j = 0; j < COLS; j++) skew_b[c][j] <= '0;
            end
        end else if (start_ok) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int j = 0; j < ROWS; j++) skew_a[r][j] <= '0;
                for (int c = 0; c < COLS; c++) begin
                    a_reg[r][c] <= '0;
                    b_reg[r][c] <= '0;
                    if (!bus.acc_keep) acc[r][c] <= '0;
                end
            end
            for (int c = 0; c < COLS; c++) begin
                for (int j = 0; j < COLS; j++) skew_b[c][j] <= '0;
            end
        end else if (advance) begin
            for (int r = 0; r < ROWS; r++) begin
                skew_a[r][0] <= fmap_in[r];
                for (int j = 1; j < ROWS; j++) skew_a[r][j] <= skew_a[r][j-1];
            end
            for (int c = 0; c < COLS; c++) begin
                skew_b[c][0] <= wgt_in[c];
                for (int j = 1; j < COLS; j++) skew_b[c][j] <= skew_b[c][j-1];
            end
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    a_reg[r][c] <= a_in[r][c];
                    b_reg[r][c] <= b_in[r][c];
                    acc[r][c]   <= acc[r][c] + ACC_BW'(prod[r][c]);
                end
            end
        end
    end

    always_comb begin
        result_row = '0;
        if (state == ST_DRAIN) begin
            for (int c = 0; c < COLS; c++) begin
                result_row[c*ACC_BW +: ACC_BW] = acc[row_idx][c];
            end
        end
    end
endmodule

// File: tb/tb_systolic_array_os.sv
// Directed bench for systolic_array_os on a 4x4 array with 16-bit accumulators.
module tb_systolic_array_os;
    localparam int I_F_BW = 8;
    localparam int W_BW   = 8;
    localparam int ACC_BW = 16;
    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int K_BW   = 12;
    localparam int GUARD  = 200;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int n_cmp = 0;
    int n_err = 0;

    int a_m [ROWS][8];
    int b_m [8][COLS];
    int got [ROWS][COLS];

    systolic_array_os_if #(
        .I_F_BW(I_F_BW), .W_BW(W_BW), .ACC_BW(ACC_BW),
        .ROWS(ROWS), .COLS(COLS), .K_BW(K_BW)
    ) bus ();

    systolic_array_os #(
        .I_F_BW(I_F_BW), .W_BW(W_BW), .ACC_BW(ACC_BW),
        .ROWS(ROWS), .COLS(COLS), .K_BW(K_BW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic idle_inputs();
        bus.start     = 1'b0;
        bus.acc_keep  = 1'b0;
        bus.k_len     = '0;
        bus.in_valid  = 1'b0;
        bus.i_fmap    = '0;
        bus.i_weight  = '0;
        bus.out_ready = 1'b0;
    endtask

    task automatic drive_beat(input int k);
        for (int r = 0; r < ROWS; r++) bus.i_fmap[r*I_F_BW +: I_F_BW] = 8'(a_m[r][k]);
        for (int c = 0; c < COLS; c++) bus.i_weight[c*W_BW +: W_BW] = 8'(b_m[k][c]);
    endtask

    // Full tile: start, feed, wait, drain into got[][], check done pulse.
    task automatic run_tile(input bit keep, input int klen, input bit stall_in,
                            input bit stall_out, output int lat);
        int cyc, beat, rows, guard;
        bit hold, rdy;
        logic [COLS*ACC_BW-1:0] saved_res;
        logic [1:0] saved_idx;
        lat = -1;
        bus.start = 1'b1; bus.acc_keep = keep; bus.k_len = K_BW'(klen);
        @(posedge clk); #1; cyc = 1;
        bus.start = 1'b0; bus.acc_keep = 1'b0; bus.k_len = '0;
        beat = 0; guard = 0;
        while (beat < klen && guard < GUARD) begin
            bus.in_valid = stall_in ? cyc[0] : 1'b1;
            drive_beat(beat);
            if (bus.in_valid && bus.in_ready) beat++;
            @(posedge clk); #1; cyc++; guard++;
        end
        bus.in_valid = 1'b0; bus.i_fmap = '0; bus.i_weight = '0;
        if (beat < klen) begin
            n_cmp++; n_err++;
            $display("FAIL beats_accepted: got %0d required %0d", beat, klen);
            return;
        end
        guard = 0;
        while (!bus.out_valid && guard < GUARD) begin
            n_cmp++;
            if (bus.in_ready !== 1'b0) begin
                n_err++; $display("FAIL in_ready_flush: got %b required 0", bus.in_ready);
            end
            @(posedge clk); #1; cyc++; guard++;
        end
        n_cmp++;
        if (bus.out_valid !== 1'b1) begin
            n_err++; $display("FAIL out_valid_timeout: got %b required 1", bus.out_valid);
            return;
        end
        lat = cyc;
        rows = 0; guard = 0; hold = 1'b0;
        saved_res = '0; saved_idx = '0;
        while (rows < ROWS && guard < GUARD) begin
            rdy = stall_out ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.out_ready = rdy;
            n_cmp++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL drain_flags: in_ready=%b out_valid=%b required 0/1",
                         bus.in_ready, bus.out_valid);
            end
            if (hold) begin
                n_cmp++;
                if (bus.o_result !== saved_res || bus.o_row_idx !== saved_idx) begin
                    n_err++;
                    $display("FAIL stall_stable: got row %0d %h required row %0d %h",
                             bus.o_row_idx, bus.o_result, saved_idx, saved_res);
                end
            end
            if (rdy) begin
                n_cmp++;
                if (bus.o_row_idx !== 2'(rows)) begin
                    n_err++; $display("FAIL row_idx: got %0d required %0d", bus.o_row_idx, rows);
                end
                for (int c = 0; c < COLS; c++)
                    got[rows][c] = int'($signed(bus.o_result[c*ACC_BW +: ACC_BW]));
                rows++;
                hold = 1'b0;
            end else begin
                hold = 1'b1; saved_res = bus.o_result; saved_idx = bus.o_row_idx;
            end
            @(posedge clk); #1; guard++;
        end
        bus.out_ready = 1'b0;
        n_cmp++;
        if (bus.done !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL done_pulse: done=%b out_valid=%b required 1/0", bus.done, bus.out_valid);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL done_single: done=%b busy=%b required 0/0", bus.done, bus.busy);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if ({bus.in_ready, bus.out_valid, bus.busy, bus.done, bus.o_row_idx, bus.o_result} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b busy=%b done=%b idx=%0d res=%h required all 0",
                     bus.in_ready, bus.out_valid, bus.busy, bus.done, bus.o_row_idx, bus.o_result);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_identity();
        int lat;
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < 4; k++) a_m[r][k] = (r == k) ? 1 : 0;
        for (int k = 0; k < 4; k++)
            for (int c = 0; c < COLS; c++) b_m[k][c] = k * 4 + c;
        run_tile(1'b0, 4, 1'b0, 1'b0, lat);
        n_cmp++;
        if (lat !== 12) begin
            n_err++; $display("FAIL latency: got %0d required 12", lat);
        end
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                n_cmp++;
                if (got[r][c] !== r * 4 + c) begin
                    n_err++;
                    $display("FAIL identity[%0d][%0d]: got %0d required %0d", r, c, got[r][c], r * 4 + c);
                end
            end
    endtask

    task automatic test_stalls();
        int lat;
        run_tile(1'b0, 4, 1'b1, 1'b1, lat);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                n_cmp++;
                if (got[r][c] !== r * 4 + c) begin
                    n_err++;
                    $display("FAIL stalled[%0d][%0d]: got %0d required %0d", r, c, got[r][c], r * 4 + c);
                end
            end
    endtask

    task automatic test_multi_tile();
        int lat;
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < 3; k++) a_m[r][k] = r + 1;
        for (int k = 0; k < 3; k++)
            for (int c = 0; c < COLS; c++) b_m[k][c] = c + 1;
        run_tile(1'b0, 3, 1'b0, 1'b0, lat);
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < 3; k++) a_m[r][k] = -1;
        for (int k = 0; k < 3; k++)
            for (int c = 0; c < COLS; c++) b_m[k][c] = k;
        run_tile(1'b1, 3, 1'b0, 1'b0, lat);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                n_cmp++;
                if (got[r][c] !== 3 * (r + 1) * (c + 1) - 3) begin
                    n_err++;
                    $display("FAIL keep_sum[%0d][%0d]: got %0d required %0d",
                             r, c, got[r][c], 3 * (r + 1) * (c + 1) - 3);
                end
            end
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < 3; k++) a_m[r][k] = 2;
        for (int k = 0; k < 3; k++)
            for (int c = 0; c < COLS; c++) b_m[k][c] = c - k;
        run_tile(1'b0, 3, 1'b0, 1'b0, lat);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                n_cmp++;
                if (got[r][c] !== 6 * c - 6) begin
                    n_err++;
                    $display("FAIL fresh[%0d][%0d]: got %0d required %0d", r, c, got[r][c], 6 * c - 6);
                end
            end
    endtask

    task automatic test_k_zero();
        int lat;
        run_tile(1'b1, 0, 1'b0, 1'b0, lat);
        n_cmp++;
        if (lat !== 1) begin
            n_err++; $display("FAIL k0_latency: got %0d required 1", lat);
        end
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                n_cmp++;
                if (got[r][c] !== 6 * c - 6) begin
                    n_err++;
                    $display("FAIL k0_redrain[%0d][%0d]: got %0d required %0d", r, c, got[r][c], 6 * c - 6);
                end
            end
        run_tile(1'b0, 0, 1'b0, 1'b0, lat);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                n_cmp++;
                if (got[r][c] !== 0) begin
                    n_err++; $display("FAIL k0_clear[%0d][%0d]: got %0d required 0", r, c, got[r][c]);
                end
            end
    endtask

    task automatic test_wrap();
        int lat;
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < 2; k++) a_m[r][k] = -128;
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < COLS; c++) b_m[k][c] = -128;
        run_tile(1'b0, 2, 1'b0, 1'b0, lat);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                n_cmp++;
                if (got[r][c] !== -32768) begin
                    n_err++; $display("FAIL wrap[%0d][%0d]: got %0d required -32768", r, c, got[r][c]);
                end
            end
    endtask

    task automatic test_reset_mid();
        int lat, guard;
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < 4; k++) a_m[r][k] = 5;
        for (int k = 0; k < 4; k++)
            for (int c = 0; c < COLS; c++) b_m[k][c] = 7;
        bus.start = 1'b1; bus.acc_keep = 1'b0; bus.k_len = K_BW'(4);
        @(posedge clk); #1;
        bus.start = 1'b0; bus.k_len = '0;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            drive_beat(k);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_err++; $display("FAIL mid_compute_state: in_ready got %b required 1", bus.in_ready);
        end
        rst_n = 1'b0; #1;
        n_cmp++;
        if ({bus.in_ready, bus.out_valid, bus.busy, bus.done, bus.o_row_idx, bus.o_result} !== '0) begin
            n_err++;
            $display("FAIL reset_compute: got rdy=%b vld=%b busy=%b done=%b idx=%0d res=%h required all 0",
                     bus.in_ready, bus.out_valid, bus.busy, bus.done, bus.o_row_idx, bus.o_result);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        a_m[0][0] = 2; a_m[1][0] = 2; a_m[2][0] = 2; a_m[3][0] = 2;
        for (int c = 0; c < COLS; c++) b_m[0][c] = 3;
        run_tile(1'b1, 1, 1'b0, 1'b0, lat);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                n_cmp++;
                if (got[r][c] !== 6) begin
                    n_err++; $display("FAIL after_rst_compute[%0d][%0d]: got %0d required 6", r, c, got[r][c]);
                end
            end
        // Abort a tile part-way through its drain.
        bus.start = 1'b1; bus.acc_keep = 1'b0; bus.k_len = K_BW'(1);
        @(posedge clk); #1;
        bus.start = 1'b0; bus.k_len = '0;
        bus.in_valid = 1'b1; drive_beat(0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        guard = 0;
        while (!bus.out_valid && guard < GUARD) begin
            @(posedge clk); #1; guard++;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.o_row_idx !== 2'd1) begin
            n_err++;
            $display("FAIL mid_drain_state: out_valid=%b idx=%0d required 1/1", bus.out_valid, bus.o_row_idx);
        end
        rst_n = 1'b0; #1;
        n_cmp++;
        if ({bus.in_ready, bus.out_valid, bus.busy, bus.done, bus.o_row_idx, bus.o_result} !== '0) begin
            n_err++;
            $display("FAIL reset_drain: got rdy=%b vld=%b busy=%b done=%b idx=%0d res=%h required all 0",
                     bus.in_ready, bus.out_valid, bus.busy, bus.done, bus.o_row_idx, bus.o_result);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_tile(1'b1, 1, 1'b0, 1'b0, lat);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                n_cmp++;
                if (got[r][c] !== 6) begin
                    n_err++; $display("FAIL after_rst_drain[%0d][%0d]: got %0d required 6", r, c, got[r][c]);
                end
            end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_stalls();
        test_multi_tile();
        test_k_zero();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/systolic_array_os.md
Name: systolic_array_os

Overview:
Parametrised output-stationary ROWS x COLS systolic matrix-multiply engine; successor to the fixed 5x5 PE grid.
- Computes C[ROWS x COLS] = A[ROWS x K] * B[K x COLS] with run-time K.
- Generates input skew internally.
- Runs its own start/flush/drain FSM.
- Drains results row by row over a valid/ready stream.
- Sits between the fmap/weight buffers and the output/activation buffer.

Parameters:
- I_F_BW, 8, signed fmap element width
- W_BW, 8, signed weight element width
- ACC_BW, 24, signed accumulator/result width (must be >= I_F_BW+W_BW)
- ROWS, 8, PE rows (>=1)
- COLS, 8, PE columns (>=1)
- K_BW, 12, width of k_len

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin tile; sampled in IDLE only
- acc_keep  in  1  sampled with start: 1 = keep accumulators (multi-tile K), 0 = clear
- k_len  in  K_BW  reduction length, sampled with start
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid&in_ready
- i_fmap  in  ROWS*I_F_BW  A column k; row r at bits [r*I_F_BW +: I_F_BW]
- i_weight  in  COLS*W_BW  B row k; col c at bits [c*W_BW +: W_BW]
- out_valid  out  1  result row valid
- out_ready  in  1  result row consumed when out_valid&out_ready
- o_row_idx  out  $clog2(ROWS) (min 1)  index of row on o_result
- o_result  out  COLS*ACC_BW  C row; col c at [c*ACC_BW +: ACC_BW]
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse after last row handshake

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; all skew, PE, accumulator and counter registers 0. Outputs in_ready, out_valid, busy, done = 0; o_row_idx = 0; o_result = 0. Reset mid-operation aborts the tile with no drain.
- FSM states: IDLE, COMPUTE, FLUSH, DRAIN, DONE.
- IDLE:
  - start=1 latches k_len and acc_keep.
  - acc_keep=0 clears all accumulators that cycle.
  - Next state is COMPUTE if k_len!=0, else DRAIN (which outputs the unchanged accumulators).
- COMPUTE:
  - in_ready=1.
  - Each accepted beat advances the whole array one step and increments the beat counter.
  - in_valid=0 freezes the array: no shift, no MAC.
  - After beat k_len-1 is accepted, go to FLUSH.
- FLUSH:
  - in_ready=0.
  - Array advances every cycle with zero inputs for exactly ROWS+COLS-1 cycles, then DRAIN.
- Dataflow:
  - Fmap row r is delayed r stages before PE(r,0).
  - Weight column c is delayed c stages before PE(0,c).
  - Operands move one PE right/down per advance.
  - PE(r,c) does acc += fmap*weight (signed full-precision product, sign-extended), with two's-complement wrap at ACC_BW and no saturation.
  - All accumulators are final when FLUSH ends.
- DRAIN:
  - out_valid=1; o_result = accumulator row o_row_idx.
  - Row index starts at 0 and increments on each handshake.
  - o_result and o_row_idx are held stable while out_valid&!out_ready.
  - Handshake on row ROWS-1 goes to DONE.
- DONE: done=1 for one cycle, out_valid=0, then IDLE. Accumulators are retained for a following acc_keep=1 tile.
- start outside IDLE is ignored. acc_keep and k_len are ignored except with an accepted start.
- Zero-stall latency: start to first out_valid = 1 + k_len + ROWS+COLS-1 cycles.

Test Plan:
- ROWS=COLS=4, k_len=4, A=identity, B[k][c]=k*4+c, no stalls -> rows 0..3 equal B rows; first out_valid 12 cycles after start; done pulse once.
- Same data with in_valid deasserted every other cycle and out_ready random 50% -> identical results; o_result stable while stalled; in_ready never high outside COMPUTE.
- Two tiles, k_len=3 each: second with acc_keep=1 -> result = sum of both products. A third with acc_keep=0 -> fresh product only.
- k_len=0, acc_keep=0 -> all rows 0. k_len=0, acc_keep=1 -> previous result re-drained.
- ACC_BW=16, all A=B=-128, k_len=2 -> each element = 32768 wrapped to -32768 (0x8000).
- Assert rst_n low mid-COMPUTE and mid-DRAIN -> all outputs 0 immediately; next start with k_len=1, A=all 2, B=all 3 -> every element 6.
